// File: rtl/csla16_alu_pipe.sv
// Two-stage valid/ready add/sub ALU around a 16-bit carry-select adder; latency 2 cycles, 1 beat/cycle.
// Backpressure: out_ready low holds stage 2, and in_ready drops once stage 1 is also full. Optional CSLA_ALU_SAT_EN clamps signed overflow.

module CLSA_16_bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Co
);
  logic [4:0] c;
  assign c[0] = Cin;
  assign {c[1], Sum[3:0]} = {1'b0, A[3:0]} + {1'b0, B[3:0]} + {4'd0, Cin};

  // Upper nibbles precompute both carry-in cases and select on the incoming carry.
  for (genvar g = 1; g < 4; g++) begin : g_sel
    logic [4:0] r0, r1;
    assign r0 = {1'b0, A[4*g+3:4*g]} + {1'b0, B[4*g+3:4*g]};
    assign r1 = {1'b0, A[4*g+3:4*g]} + {1'b0, B[4*g+3:4*g]} + 5'd1;
    assign {c[g+1], Sum[4*g+3:4*g]} = c[g] ? r1 : r0;
  end

  assign Co = c[4];
endmodule

module csla16_alu_pipe #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [1:0]   Op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] S,
  output logic         Co,
  output logic [3:0]   Flags
);
  logic         s1_valid;
  logic [W-1:0] a1, b1;
  logic [1:0]   op1;
  logic         c_flag;
  logic         adv2;
  logic [W-1:0] bx, sum, s_res;
  logic         cin, co_raw, v;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || adv2);

  always_comb begin
    bx = op1[1] ? ~b1 : b1;
    case (op1)
      2'b00:   cin = 1'b0;
      2'b10:   cin = 1'b1;
      default: cin = c_flag;
    endcase
  end

  CLSA_16_bit u_add (
    .A   (a1),
    .B   (bx),
    .Cin (cin),
    .Sum (sum),
    .Co  (co_raw)
  );

  assign v = (a1[W-1] == bx[W-1]) && (sum[W-1] != a1[W-1]);

`ifdef CSLA_ALU_SAT_EN
  // Clamp toward the sign of A; carry still reports the raw adder output.
  always_comb begin
    s_res = sum;
    if (v) s_res = a1[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`else
  assign s_res = sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      op1       <= 2'b00;
      out_valid <= 1'b0;
      S         <= '0;
      Co        <= 1'b0;
      Flags     <= 4'd0;
      c_flag    <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        a1  <= A;
        b1  <= B;
        op1 <= Op;
      end
      if (adv2) out_valid <= s1_valid;
      if (s1_valid && adv2) begin
        S      <= s_res;
        Co     <= co_raw;
        c_flag <= co_raw;
        Flags  <= {s_res[W-1], (s_res == '0), co_raw, v};
      end
    end
  end
endmodule

// File: tb/tb_csla16_alu_pipe.sv
// Scoreboard bench for csla16_alu_pipe: the driver pushes model results, the negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_csla16_alu_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] A, B;
  logic [1:0]  Op;
  logic        out_valid, out_ready;
  logic [15:0] S;
  logic        Co;
  logic [3:0]  Flags;

  int total = 0;
  int bad   = 0;
  logic [20:0] sb[$];
  logic        m_cf;

  always #5 clk = ~clk;

  csla16_alu_pipe #(.W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Op(Op), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Co(Co), .Flags(Flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference result {S, Co, N, Z, C, V}; carry chain advances in program order.
  function automatic logic [20:0] model(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b, inout logic cf);
    logic [15:0] bx, s;
    logic [16:0] full;
    logic        ci, v;
    bx   = op[1] ? ~b : b;
    ci   = (op == 2'b00) ? 1'b0 : (op == 2'b10) ? 1'b1 : cf;
    full = {1'b0, a} + {1'b0, bx} + {16'd0, ci};
    s    = full[15:0];
    v    = (a[15] == bx[15]) && (s[15] != a[15]);
`ifdef CSLA_ALU_SAT_EN
    if (v) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    cf = full[16];
    return {s, full[16], s[15], (s == 16'd0), full[16], v};
  endfunction

  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    in_valid = 1'b1; Op = op; A = a; B = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      sb.push_back(model(op, a, b, m_cf));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_out", 32'd1, 32'd0);
      else check("result", {11'd0, S, Co, Flags}, {11'd0, sb.pop_front()});
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Op = 2'b00; out_ready = 1'b1; m_cf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_S", S, 0);
    check("rst_Co_Flags", {Co, Flags}, 0);
    rst = 1'b0;
    #1 check("in_ready_up", in_ready, 1);

    // 1: latency check
    send(2'b00, 16'h00FF, 16'h0001);
    check("lat_n1", out_valid, 0);
    @(posedge clk); #1;
    check("lat_n2", out_valid, 1);
    check("t1_S", S, 16'h0100);
    check("t1_flags", {Co, Flags}, 5'b0_0000);
    drain();

    // 2-4: carry chaining, borrow convention, signed overflow
    send(2'b00, 16'hFFFF, 16'h0001);
    send(2'b01, 16'h0000, 16'h0000);
    send(2'b10, 16'h1234, 16'h1234);
    send(2'b10, 16'h0000, 16'h0001);
    send(2'b00, 16'h7FFF, 16'h0001);
    send(2'b11, 16'h8000, 16'h0001);
    send(2'b10, 16'h8000, 16'h0001);
    drain();

    // 5: backpressure with three back-to-back beats
    out_ready = 1'b0;
    send(2'b00, 16'h1111, 16'h0001);
    send(2'b00, 16'h2222, 16'h0002);
    fork
      send(2'b10, 16'h3333, 16'h0003);
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_S", S, 16'h1112);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("bp_stream", out_valid, 1);
        end
      end
    join
    drain();

    // Random ops under random backpressure
    fork
      begin
        repeat (60) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
      for (int i = 0; i < 30; i++)
        send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
    join
    out_ready = 1'b1;
    drain();

    // 6: reset with both stages full, carry flag set beforehand
    out_ready = 1'b0;
    send(2'b00, 16'hFFFF, 16'h0001);
    send(2'b00, 16'h0005, 16'h0006);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 check("rst_mid_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_S", S, 0);
    check("rst_mid_Flags", {Co, Flags}, 0);
    sb.delete();
    m_cf = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
    #1 check("rst_mid_in_ready_up", in_ready, 1);
    send(2'b01, 16'h0000, 16'h0000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
